ballot_intake: RTL and testbench

- Front-end stage of the five-candidate voting machine. It sits directly upstream of the per-candidate vote counters.
- Takes raw candidate push-buttons plus an officer "arm" pulse. It synchronises and debounces the buttons and enforces one vote per armed session.
- Output is a one-cycle, one-hot vote pulse whose bits drive the counters' up inputs.
- Rejects multi-button presses and times out idle sessions.

---
 rtl/ballot_intake.sv | 159 +++++++++++++++
 tb/tb_ballot_intake.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_intake.sv
// Voting-machine front end: synchronises and debounces the five candidate buttons,
// enforces one vote per armed session and emits a one-cycle one-hot vote pulse.
module ballot_intake #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [4:0]  btn,
  output logic [4:0]  vote,
  output logic        ready,
  output logic        busy,
  output logic        reject,
  output logic        timeout,
  output logic [31:0] total_votes
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_DONE = CW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RELEASE,
    ARMED,
    DEBOUNCE,
    CAST
  } state_t;

  state_t        state, state_n;
  logic [4:0]    btn_m, btn_s;
  logic [4:0]    capture, cap_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic          cast_done, done_n;
  logic [4:0]    vote_n;
  logic          reject_n, timeout_n;
  logic [31:0]   total_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      capture     <= '0;
      cnt         <= '0;
      timer       <= '0;
      cast_done   <= 1'b0;
      vote        <= '0;
      reject      <= 1'b0;
      timeout     <= 1'b0;
      total_votes <= '0;
    end else begin
      state       <= state_n;
      capture     <= cap_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
      cast_done   <= done_n;
      vote        <= vote_n;
      reject      <= reject_n;
      timeout     <= timeout_n;
      total_votes <= total_n;
    end
  end

  always_comb begin
    state_n   = state;
    cap_n     = capture;
    cnt_n     = cnt;
    timer_n   = timer;
    done_n    = cast_done;
    vote_n    = '0;
    reject_n  = 1'b0;
    timeout_n = 1'b0;
    total_n   = total_votes;

    case (state)
      IDLE: begin
        if (arm) begin
          state_n = RELEASE;
          cnt_n   = '0;
          done_n  = 1'b0;
        end
      end
      // Buttons must read released for a full debounce window before the voter may press.
      RELEASE: begin
        if (btn_s != '0) begin
          cnt_n = '0;
        end else if (cnt + CW'(1) == DEB_DONE) begin
          cnt_n = '0;
          if (cast_done) begin
            state_n = IDLE;
          end else begin
            state_n = ARMED;
            timer_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ARMED: begin
        if (btn_s != '0) begin
          cap_n   = btn_s;
          cnt_n   = CW'(1);
          state_n = DEBOUNCE;
        end else if (TIMEOUT_CYCLES != 0 && timer == TMO_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DEBOUNCE: begin
        if (btn_s == '0) begin
          state_n = ARMED;
        end else if (btn_s == capture) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cap_n = btn_s;
          cnt_n = CW'(1);
        end
      end
      CAST: begin
        state_n = RELEASE;
        cnt_n   = '0;
        done_n  = 1'b1;
        total_n = total_votes + 32'd1;
      end
      default: state_n = IDLE;
    endcase

    // Accept decision shared by ARMED (single-cycle debounce) and DEBOUNCE.
    if ((state == ARMED || state == DEBOUNCE) && btn_s != '0 && cnt_n == DEB_DONE) begin
      if ((cap_n & (cap_n - 5'd1)) == '0) begin
        state_n = CAST;
        vote_n  = cap_n;
      end else begin
        state_n  = RELEASE;
        cnt_n    = '0;
        done_n   = 1'b0;
        reject_n = 1'b1;
      end
    end
  end

  assign ready = (state == ARMED) || (state == DEBOUNCE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ballot_intake.sv
// Randomised session bench for ballot_intake: a session-level reference model predicts
// pulses into a scoreboard queue that a separate monitor drains as the DUT emits them.
module tb_ballot_intake;

  localparam int D = 4;
  localparam int T = 20;

  localparam int P_IDLE    = 0;
  localparam int P_SETTLE  = 1;
  localparam int P_WAITING = 2;
  localparam int P_HOLDING = 3;
  localparam int P_CASTING = 4;

  localparam int K_VOTE    = 1;
  localparam int K_REJECT  = 2;
  localparam int K_TIMEOUT = 3;

  typedef struct {
    int         kind;
    logic [4:0] val;
    int         cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [4:0]  btn = '0;
  logic [4:0]  vote;
  logic        ready;
  logic        busy;
  logic        reject;
  logic        timeout;
  logic [31:0] total_votes;

  ballot_intake #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .btn(btn),
    .vote(vote),
    .ready(ready),
    .busy(busy),
    .reject(reject),
    .timeout(timeout),
    .total_votes(total_votes)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          started  = 1'b0;
  ev_t         q[$];

  int          phase = P_IDLE;
  int          quiet_run, hold_run, wait_cycles;
  logic [4:0]  held;
  bit          voted;
  logic [4:0]  s1 = '0, s2 = '0;
  logic [31:0] exp_total = '0;
  logic        exp_ready = 1'b0, exp_busy = 1'b0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // A debounced press either becomes a vote (exactly one button) or a rejected retry.
  task automatic decide();
    if ($countones(held) == 1) begin
      phase = P_CASTING;
      q.push_back('{K_VOTE, held, cyc});
    end else begin
      phase     = P_SETTLE;
      quiet_run = 0;
      voted     = 1'b0;
      q.push_back('{K_REJECT, 5'b0, cyc});
    end
  endtask

  task automatic model_step(input logic a, input logic [4:0] s);
    case (phase)
      P_IDLE: if (a) begin
        phase     = P_SETTLE;
        quiet_run = 0;
        voted     = 1'b0;
      end
      P_SETTLE: begin
        quiet_run = (s == 0) ? quiet_run + 1 : 0;
        if (quiet_run == D) begin
          if (voted) phase = P_IDLE;
          else begin
            phase       = P_WAITING;
            wait_cycles = 0;
          end
        end
      end
      P_WAITING: begin
        if (s != 0) begin
          held     = s;
          hold_run = 1;
          phase    = P_HOLDING;
          if (hold_run == D) decide();
        end else if (wait_cycles == T - 1) begin
          phase = P_IDLE;
          q.push_back('{K_TIMEOUT, 5'b0, cyc});
        end else begin
          wait_cycles++;
        end
      end
      P_HOLDING: begin
        if (s == 0) phase = P_WAITING;
        else begin
          if (s == held) hold_run++;
          else begin
            held     = s;
            hold_run = 1;
          end
          if (hold_run == D) decide();
        end
      end
      default: begin
        phase     = P_SETTLE;
        quiet_run = 0;
        voted     = 1'b1;
        exp_total = exp_total + 32'd1;
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        phase     = P_IDLE;
        exp_total = '0;
        s1        = '0;
        s2        = '0;
        started   = 1'b1;
      end else begin
        model_step(arm, s2);
        s2 = s1;
        s1 = btn;
      end
      exp_ready = (phase == P_WAITING) || (phase == P_HOLDING);
      exp_busy  = (phase != P_IDLE);
    end
  end

  initial begin
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (started) begin
        check_output("ready", 32'(ready), 32'(exp_ready));
        check_output("busy", 32'(busy), 32'(exp_busy));
        check_output("total_votes", total_votes, exp_total);
        if (vote != 0 || reject || timeout) begin
          check_output("pulse_exclusive", 32'((vote != 0) + reject + timeout), 32'd1);
          check_output("vote_onehot_or_zero", 32'($countones(vote) <= 1), 32'd1);
          kind = (vote != 0) ? K_VOTE : (reject ? K_REJECT : K_TIMEOUT);
          if (q.size() == 0) begin
            check_output("unexpected_pulse_kind", 32'(kind), 32'd0);
          end else begin
            e = q.pop_front();
            check_output("pulse_kind", 32'(kind), 32'(e.kind));
            check_output("vote_value", 32'(vote), 32'(e.val));
            check_output("pulse_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        if (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          check_output("missing_pulse_kind", 32'd0, 32'(e.kind));
        end
      end
    end
  end

  task automatic hold(input logic a, input logic [4:0] b, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      arm = a;
      btn = b;
      rst = r;
      @(negedge clk);
    end
  endtask

  function automatic logic [4:0] rand_onehot();
    logic [4:0] one = 5'b00001;
    return one << $urandom_range(0, 4);
  endfunction

  function automatic logic [4:0] rand_multi();
    logic [4:0] v;
    do v = 5'($urandom); while ($countones(v) < 2);
    return v;
  endfunction

  task automatic clean_vote();
    hold(1, 0, 0, 1);
    hold(0, 0, 0, 6);
    hold(0, rand_onehot(), 0, $urandom_range(5, 12));
    hold(0, 0, 0, 8);
  endtask

  task automatic apply_stimulus(input int kind);
    logic [4:0] v;
    case (kind)
      0: begin
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 6);
        v = rand_onehot();
        for (int i = 0; i < 10; i++) hold(1'($urandom_range(0, 1)), v, 0, 1);
        hold(0, 0, 0, 8);
        hold(0, rand_onehot(), 0, 3);
        hold(0, 0, 0, 3);
      end
      1: begin
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 6);
        hold(0, rand_onehot(), 0, $urandom_range(1, 3));
        hold(0, 0, 0, 3);
        hold(0, rand_onehot(), 0, 8);
        hold(0, 0, 0, 8);
      end
      2: begin
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 6);
        hold(0, rand_multi(), 0, 8);
        hold(0, 0, 0, 6);
        hold(0, rand_onehot(), 0, 8);
        hold(0, 0, 0, 8);
      end
      3: begin
        v = rand_onehot();
        hold(0, v, 0, 2);
        hold(1, v, 0, 1);
        hold(0, v, 0, $urandom_range(3, 8));
        hold(0, 0, 0, 6);
        hold(0, rand_onehot(), 0, 8);
        hold(0, 0, 0, 8);
      end
      4: begin
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 30);
        clean_vote();
      end
      5: begin
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 6);
        hold(0, 5'b01000, 0, 4);
        hold(0, 5'b01000, 1, 1);
        hold(0, 0, 0, 4);
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 6);
        hold(0, rand_onehot(), 0, $urandom_range(5, 8));
        hold(0, 0, 1, 1);
        hold(0, 0, 0, 3);
        clean_vote();
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          if ($urandom_range(0, 2) == 0) v = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom);
          hold(1'($urandom_range(0, 5) == 0), v, 0, 1);
        end
        hold(0, 0, 0, 10);
      end
    endcase
  endtask

  initial begin
    hold(0, 0, 1, 2);
    for (int k = 0; k <= 6; k++) apply_stimulus(k);
    for (int n = 0; n < 40; n++) apply_stimulus($urandom_range(0, 6));
    hold(0, 0, 0, 40);
    check_output("final_total_votes", total_votes, exp_total);
    check_output("final_idle", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
